// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: stage registers, MEM FSM states, funct3 encodings
// and the byte-lane helpers used by the MEM stage.
package rv32i_types;

   localparam int unsigned DW = 32;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef struct packed {
      logic          commit;
      logic [63:0]   order;
      logic [DW-1:0] inst;
      logic [DW-1:0] pc;
      logic [DW-1:0] pc_next;
      logic [4:0]    rs1_s;
      logic [4:0]    rs2_s;
      logic [DW-1:0] rs1_v;
      logic [DW-1:0] rs2_v;
      logic [4:0]    rd_s;
      logic [DW-1:0] rd_v;
      logic          regf_we;
      logic          mem_read;
      logic          mem_write;
      logic [2:0]    funct3;
      logic [DW-1:0] mem_addr;
   } ex_mem_reg_t;

   typedef struct packed {
      logic          commit;
      logic [63:0]   order;
      logic [DW-1:0] inst;
      logic [DW-1:0] pc;
      logic [DW-1:0] pc_next;
      logic [4:0]    rs1_s;
      logic [4:0]    rs2_s;
      logic [DW-1:0] rs1_v;
      logic [DW-1:0] rs2_v;
      logic [4:0]    rd_s;
      logic [DW-1:0] rd_v;
      logic          regf_we;
      logic [DW-1:0] dmem_addr;
      logic [3:0]    dmem_rmask;
      logic [3:0]    dmem_wmask;
      logic [DW-1:0] dmem_wdata;
      logic [DW-1:0] dmem_rdata;
   } mem_wb_reg_t;

   // Byte-lane mask for an access of the given size (funct3[1:0]) at a byte offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         2'b00:   return 4'b0001 << offset;
         2'b01:   return 4'b0011 << offset;
         default: return 4'b1111;
      endcase
   endfunction

   // Half/word accesses must be naturally aligned.
   function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return offset[0];
         default: return offset != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bundle between the MEM stage and the data memory.
interface mem_stage_if;

   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;

   modport master (
      output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      input  dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      output dmem_rdata, dmem_resp
   );

endinterface

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module load_align
   import rv32i_types::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rd_v
);

   logic [31:0] shifted;

   // Move the addressed byte lane to bit 0, then extend per load type.
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (load_funct3_t'(funct3))
         lb:      rd_v = {{24{shifted[7]}}, shifted[7:0]};
         lbu:     rd_v = {24'h0, shifted[7:0]};
         lh:      rd_v = {{16{shifted[15]}}, shifted[15:0]};
         lhu:     rd_v = {16'h0, shifted[15:0]};
         default: rd_v = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory requests, stalls upstream while one is outstanding,
// aligns load data and registers a fully populated mem_wb_reg for WB and RVFI.
module mem_stage
   import rv32i_types::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  ex_mem_reg_t        ex_mem_reg,
   mem_stage_if.master        dmem,
   output logic               mem_stall,
   output mem_wb_reg_t        mem_wb_reg
);

   if (XLEN != 32) begin : g_xlen_check
      $error("mem_stage supports XLEN=32 only");
   end

   mem_state_t  state_q, state_d;
   mem_wb_reg_t pend_q, pend_d;
   mem_wb_reg_t wb_d;
   mem_wb_reg_t rec;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  offset_q, offset_d;
   logic        load_q, load_d;
   logic [1:0]  offset;
   logic [3:0]  mask;
   logic        is_mem;
   logic [31:0] load_v;

   assign offset = ex_mem_reg.mem_addr[1:0];
   assign mask   = lane_mask(ex_mem_reg.funct3[1:0], offset);

   // Misaligned half/word accesses fall through as ordinary non-memory ops.
   assign is_mem = ex_mem_reg.commit & (ex_mem_reg.mem_read | ex_mem_reg.mem_write) &
                   ~lane_misaligned(ex_mem_reg.funct3[1:0], offset);

   // Build the WB record for the incoming instruction, including monitor fields.
   always_comb begin
      rec            = '0;
      rec.commit     = ex_mem_reg.commit;
      rec.order      = ex_mem_reg.order;
      rec.inst       = ex_mem_reg.inst;
      rec.pc         = ex_mem_reg.pc;
      rec.pc_next    = ex_mem_reg.pc_next;
      rec.rs1_s      = ex_mem_reg.rs1_s;
      rec.rs2_s      = ex_mem_reg.rs2_s;
      rec.rs1_v      = ex_mem_reg.rs1_v;
      rec.rs2_v      = ex_mem_reg.rs2_v;
      rec.rd_s       = ex_mem_reg.rd_s;
      rec.rd_v       = ex_mem_reg.rd_v;
      rec.regf_we    = ex_mem_reg.regf_we;
      if (is_mem) begin
         rec.dmem_addr = {ex_mem_reg.mem_addr[31:2], 2'b00};
         if (ex_mem_reg.mem_read) begin
            rec.dmem_rmask = mask;
         end else begin
            rec.dmem_wmask = mask;
            rec.dmem_wdata = ex_mem_reg.rs2_v << {offset, 3'b000};
         end
      end
   end

   load_align u_load_align (
      .rdata  (dmem.dmem_rdata),
      .offset (offset_q),
      .funct3 (funct3_q),
      .rd_v   (load_v)
   );

   // Next-state, request outputs, stall and WB record selection.
   always_comb begin
      state_d         = state_q;
      pend_d          = pend_q;
      funct3_d        = funct3_q;
      offset_d        = offset_q;
      load_d          = load_q;
      wb_d            = '0;
      mem_stall       = 1'b0;
      dmem.dmem_addr  = '0;
      dmem.dmem_rmask = '0;
      dmem.dmem_wmask = '0;
      dmem.dmem_wdata = '0;
      case (state_q)
         IDLE: begin
            // rst gates the combinational request so nothing leaks out during reset.
            if (is_mem && !rst) begin
               dmem.dmem_addr  = rec.dmem_addr;
               dmem.dmem_rmask = rec.dmem_rmask;
               dmem.dmem_wmask = rec.dmem_wmask;
               dmem.dmem_wdata = rec.dmem_wdata;
               mem_stall       = 1'b1;
               pend_d          = rec;
               funct3_d        = ex_mem_reg.funct3;
               offset_d        = offset;
               load_d          = ex_mem_reg.mem_read;
               state_d         = WAIT;
            end else if (ex_mem_reg.commit) begin
               wb_d = rec;
            end
         end
         WAIT: begin
            if (dmem.dmem_resp) begin
               wb_d        = pend_q;
               wb_d.commit = 1'b1;
               if (load_q) begin
                  wb_d.dmem_rdata = dmem.dmem_rdata;
                  wb_d.rd_v       = load_v;
               end
               state_d = IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pending request and output pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         funct3_q   <= '0;
         offset_q   <= '0;
         load_q     <= 1'b0;
         mem_wb_reg <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         funct3_q   <= funct3_d;
         offset_q   <= offset_d;
         load_q     <= load_d;
         mem_wb_reg <= wb_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected requests and commits,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_stage;
   import rv32i_types::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   ex_mem_reg_t ex;
   logic        mem_stall;
   mem_wb_reg_t wb;

   mem_stage_if dmem_bus ();

   mem_stage #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_mem_reg (ex),
      .dmem       (dmem_bus),
      .mem_stall  (mem_stall),
      .mem_wb_reg (wb)
   );

   always #5 clk = ~clk;

   mem_wb_reg_t exp_q[$];
   req_t        req_q[$];
   int          total = 0;
   int          bad = 0;
   int          stall_cycles = 0;
   req_t        got_r, exp_r;
   mem_wb_reg_t exp_w;

   // Monitor: every request pulse and every commit must match the next queued entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_stall) stall_cycles++;
         if (dmem_bus.dmem_rmask != 4'b0 || dmem_bus.dmem_wmask != 4'b0) begin
            got_r.addr  = dmem_bus.dmem_addr;
            got_r.rmask = dmem_bus.dmem_rmask;
            got_r.wmask = dmem_bus.dmem_wmask;
            got_r.wdata = dmem_bus.dmem_wdata;
            total++;
            if (req_q.size() == 0) begin
               bad++;
               $display("FAIL req_unexpected got=%h at %0t", got_r, $time);
            end else begin
               exp_r = req_q.pop_front();
               if (got_r !== exp_r) begin
                  bad++;
                  $display("FAIL req got=%h want=%h at %0t", got_r, exp_r, $time);
               end
            end
         end
         if (wb.commit) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL commit_unexpected order=%0d rd_v=%h", wb.order, wb.rd_v);
            end else begin
               exp_w = exp_q.pop_front();
               if (wb !== exp_w) begin
                  bad++;
                  $display("FAIL commit order got=%0d want=%0d rd_v got=%h want=%h full got=%h want=%h",
                           wb.order, exp_w.order, wb.rd_v, exp_w.rd_v, wb, exp_w);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   function automatic ex_mem_reg_t mk(input logic [63:0] order, input logic [2:0] f3,
                                      input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] rs2, input logic [31:0] rdv,
                                      input logic we);
      ex_mem_reg_t e;
      e           = '0;
      e.commit    = 1'b1;
      e.order     = order;
      e.inst      = 32'h0000_0003 ^ {order[15:0], 16'h0};
      e.pc        = 32'h0000_1000 + (order[31:0] << 2);
      e.pc_next   = e.pc + 32'd4;
      e.rs1_s     = 5'd1;
      e.rs2_s     = 5'd2;
      e.rs1_v     = addr;
      e.rs2_v     = rs2;
      e.rd_s      = we ? 5'd3 : 5'd0;
      e.rd_v      = rdv;
      e.regf_we   = we;
      e.mem_read  = rd;
      e.mem_write = wr;
      e.funct3    = f3;
      e.mem_addr  = addr;
      return e;
   endfunction

   function automatic mem_wb_reg_t wb_of(input ex_mem_reg_t e, input logic [31:0] a,
                                         input logic [3:0] rm, input logic [3:0] wm,
                                         input logic [31:0] wd, input logic [31:0] rdat,
                                         input logic [31:0] rdv);
      mem_wb_reg_t w;
      w            = '0;
      w.commit     = 1'b1;
      w.order      = e.order;
      w.inst       = e.inst;
      w.pc         = e.pc;
      w.pc_next    = e.pc_next;
      w.rs1_s      = e.rs1_s;
      w.rs2_s      = e.rs2_s;
      w.rs1_v      = e.rs1_v;
      w.rs2_v      = e.rs2_v;
      w.rd_s       = e.rd_s;
      w.rd_v       = rdv;
      w.regf_we    = e.regf_we;
      w.dmem_addr  = a;
      w.dmem_rmask = rm;
      w.dmem_wmask = wm;
      w.dmem_wdata = wd;
      w.dmem_rdata = rdat;
      return w;
   endfunction

   function automatic req_t rq(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                               input logic [31:0] wd);
      req_t r;
      r.addr  = a;
      r.rmask = rm;
      r.wmask = wm;
      r.wdata = wd;
      return r;
   endfunction

   // Memory op: request cycle, then resp in cycle 'delay' after the request.
   task automatic mem_op(input ex_mem_reg_t e, input int delay, input logic [31:0] rdat,
                         input req_t r, input mem_wb_reg_t w);
      @(posedge clk); #1;
      ex = e;
      dmem_bus.dmem_resp = 1'b0;
      req_q.push_back(r);
      exp_q.push_back(w);
      for (int i = 1; i < delay; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = rdat;
      @(negedge clk);
      check("stall_on_resp", {63'h0, mem_stall}, 64'h0);
   endtask

   task automatic plain_op(input ex_mem_reg_t e, input mem_wb_reg_t w);
      @(posedge clk); #1;
      ex = e;
      dmem_bus.dmem_resp = 1'b0;
      exp_q.push_back(w);
      @(negedge clk);
      check("plain_stall", {63'h0, mem_stall}, 64'h0);
      check("plain_masks", {56'h0, dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}, 64'h0);
   endtask

   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         ex = '0;
         dmem_bus.dmem_resp = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      ex_mem_reg_t e;
      rst = 1'b1;
      dmem_bus.dmem_resp  = 1'b0;
      dmem_bus.dmem_rdata = 32'h0;
      // A memory op on the input during reset must not produce a request.
      ex = mk(64'd0, 3'b010, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1);
      #12;
      check("rst_masks", {56'h0, dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}, 64'h0);
      check("rst_stall", {63'h0, mem_stall}, 64'h0);
      check("rst_addr_wdata", {dmem_bus.dmem_addr, dmem_bus.dmem_wdata}, 64'h0);
      check("rst_wb_commit", {63'h0, wb.commit}, 64'h0);
      check("rst_wb_all", {32'h0, wb.rd_v}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      ex  = '0;

      // LW 0x100, resp 3 cycles after request.
      e = mk(64'd1, 3'b010, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b1);
      mem_op(e, 3, 32'hDEAD_BEEF, rq(32'h100, 4'b1111, 4'b0, 32'h0),
             wb_of(e, 32'h100, 4'b1111, 4'b0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
      bubble(1);

      // LB / LBU at 0x103.
      e = mk(64'd2, 3'b000, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0103, 1'b1);
      mem_op(e, 1, 32'h80AA_BBCC, rq(32'h100, 4'b1000, 4'b0, 32'h0),
             wb_of(e, 32'h100, 4'b1000, 4'b0, 32'h0, 32'h80AA_BBCC, 32'hFFFF_FF80));
      e = mk(64'd3, 3'b100, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0103, 1'b1);
      mem_op(e, 1, 32'h80AA_BBCC, rq(32'h100, 4'b1000, 4'b0, 32'h0),
             wb_of(e, 32'h100, 4'b1000, 4'b0, 32'h0, 32'h80AA_BBCC, 32'h0000_0080));

      // SH at 0x102; response data must not reach the WB record.
      e = mk(64'd4, 3'b001, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_1234, 32'h0000_0102, 1'b0);
      mem_op(e, 2, 32'hFFFF_FFFF, rq(32'h100, 4'b0, 4'b1100, 32'h1234_0000),
             wb_of(e, 32'h100, 4'b0, 4'b1100, 32'h1234_0000, 32'h0, 32'h0000_0102));

      // ADDI, then a misaligned LW that must pass through as a plain op.
      e = mk(64'd5, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0005, 1'b1);
      plain_op(e, wb_of(e, 32'h0, 4'b0, 4'b0, 32'h0, 32'h0, 32'h5));
      e = mk(64'd6, 3'b010, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_0102, 1'b1);
      plain_op(e, wb_of(e, 32'h0, 4'b0, 4'b0, 32'h0, 32'h0, 32'h0000_0102));

      // Back-to-back LWs, then LHU / LH on the upper half.
      e = mk(64'd7, 3'b010, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0200, 1'b1);
      mem_op(e, 1, 32'h1111_1111, rq(32'h200, 4'b1111, 4'b0, 32'h0),
             wb_of(e, 32'h200, 4'b1111, 4'b0, 32'h0, 32'h1111_1111, 32'h1111_1111));
      e = mk(64'd8, 3'b010, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h0000_0204, 1'b1);
      mem_op(e, 1, 32'h2222_2222, rq(32'h204, 4'b1111, 4'b0, 32'h0),
             wb_of(e, 32'h204, 4'b1111, 4'b0, 32'h0, 32'h2222_2222, 32'h2222_2222));
      e = mk(64'd9, 3'b101, 1'b1, 1'b0, 32'h0000_0206, 32'h0, 32'h0000_0206, 1'b1);
      mem_op(e, 1, 32'hABCD_0000, rq(32'h204, 4'b1100, 4'b0, 32'h0),
             wb_of(e, 32'h204, 4'b1100, 4'b0, 32'h0, 32'hABCD_0000, 32'h0000_ABCD));
      e = mk(64'd10, 3'b001, 1'b1, 1'b0, 32'h0000_0206, 32'h0, 32'h0000_0206, 1'b1);
      mem_op(e, 1, 32'hABCD_0000, rq(32'h204, 4'b1100, 4'b0, 32'h0),
             wb_of(e, 32'h204, 4'b1100, 4'b0, 32'h0, 32'hABCD_0000, 32'hFFFF_ABCD));
      bubble(2);

      // Reset two cycles into WAIT; a late response must not produce a commit.
      e = mk(64'd11, 3'b010, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_0300, 1'b1);
      @(posedge clk); #1;
      ex = e;
      req_q.push_back(rq(32'h300, 4'b1111, 4'b0, 32'h0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      ex  = '0;
      @(negedge clk);
      check("rst_wait_state", {63'h0, dut.state_q}, {63'h0, IDLE});
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("late_resp_stall", {63'h0, mem_stall}, 64'h0);
      @(posedge clk); #1;
      dmem_bus.dmem_resp = 1'b0;
      @(negedge clk);
      check("late_resp_commit", {63'h0, wb.commit}, 64'h0);
      check("late_resp_state", {63'h0, dut.state_q}, {63'h0, IDLE});

      bubble(4);
      @(negedge clk);
      check("commits_drained", 64'(exp_q.size()), 64'h0);
      check("reqs_drained", 64'(req_q.size()), 64'h0);
      check("stall_cycles", 64'(stall_cycles), 64'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the rv32i five-stage core. Sits between the EX/MEM register and the WB stage.
- Consumes ex_mem_reg and issues data-memory requests. Waits for the dmem response, aligns and sign-extends load data, and registers a fully populated mem_wb_reg that carries all RVFI monitor fields.
- Stalls the upstream pipeline while a dmem transaction is outstanding.

Parameters:
- XLEN, 32: datapath width. Only 32 is supported; it exists for elaboration checks.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_mem_reg  in  ex_mem_reg_t  from EX. Fields: commit, order, inst, pc, pc_next, rs1_s, rs2_s, rs1_v, rs2_v, rd_s, rd_v (ALU result), regf_we, mem_read, mem_write, funct3, mem_addr (byte address)
- dmem_addr  out  32  word-aligned request address
- dmem_rmask  out  4  byte read mask; nonzero for one cycle = read request
- dmem_wmask  out  4  byte write mask; nonzero for one cycle = write request
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle response strobe
- mem_stall  out  1  high = upstream holds ex_mem_reg and pc stable
- mem_wb_reg  out  mem_wb_reg_t  registered output to WB stage

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mem_wb_reg cleared to all-zero, so commit=0.
  - dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata = 0.
  - mem_stall=0.
- A memory op is ex_mem_reg.commit & (mem_read | mem_write). A non-memory op is commit=1 with neither set. A bubble is commit=0.
- Address and lane rules (offset = mem_addr[1:0]):
  - dmem_addr = {mem_addr[31:2], 2'b00}.
  - Byte op: mask = 4'b0001 << offset.
  - Half op: mask = 4'b0011 << offset.
  - Word op: mask = 4'b1111.
  - dmem_wdata = rs2_v << (8*offset).
  - Misaligned half/word (offset not naturally aligned) issues no request. It passes through as a non-memory op with masks 0. It must never hang.
- FSM states: IDLE, WAIT.
  - IDLE, memory op: drive request combinationally this cycle (masks valid exactly one cycle), assert mem_stall, latch the request fields, go to WAIT. mem_wb_reg is loaded with a bubble (commit=0) at the clock edge.
  - IDLE, non-memory op: mem_wb_reg <= ex_mem_reg fields, with dmem_* = 0 and commit=1. One-cycle latency, no stall.
  - IDLE, bubble: mem_wb_reg.commit <= 0.
  - WAIT, dmem_resp=0: masks=0 (no re-request), mem_stall=1, mem_wb_reg.commit <= 0.
  - WAIT, dmem_resp=1: mem_stall=0 in the same cycle so EX advances at this edge. mem_wb_reg <= latched fields with commit=1 and dmem_rdata captured. Go to IDLE.
- Load result for WB:
  - rd_v = extracted field, shifted right by 8*offset, then:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: full word.
- mem_wb_reg.rd_v for stores and non-memory ops is ex_mem_reg.rd_v. regf_we is passed unchanged; stores carry regf_we=0.
- mem_wb_reg monitor fields:
  - dmem_addr: the aligned address.
  - dmem_rmask / dmem_wmask: the shifted masks.
  - dmem_wdata: the shifted store data.
  - dmem_rdata: raw response data, 0 for non-loads.
- Ordering rules:
  - order values are taken from ex_mem_reg unchanged. Each committed instruction appears in mem_wb_reg with commit=1 exactly once.
  - Stall cycles emit commit=0 only.
- Boundary conditions:
  - dmem_resp while in IDLE is ignored.
  - Reset asserted in WAIT aborts to IDLE. A response that arrives after reset deasserts is ignored.
  - Back-to-back memory ops: the next request issues in the cycle after the resp edge, never in the same cycle as resp.
  - Minimum load/store latency: request cycle + 1 = 2 cycles to mem_wb_reg.commit.

Decomposition:
- rv32i_types holds:
  - ex_mem_reg_t and mem_wb_reg_t (shared with ex_stage and wb_stage)
  - mem_state_t enum {IDLE, WAIT}
  - load_funct3_t {lb, lh, lw, lbu, lhu}
  - store_funct3_t {sb, sh, sw}
- Sub-module load_align: combinational (rdata, offset, funct3) -> rd_v. It is reused by any future forwarding path.

Test Plan:
- LW at 0x0000_0100, dmem_resp 3 cycles after request with rdata 0xDEADBEEF:
  - rmask=1111 for one cycle; mem_stall high 3 cycles.
  - mem_wb_reg.commit=1 once, rd_v=0xDEADBEEF, dmem_addr=0x100.
- LB at 0x103, rdata 0x80AA_BBCC, resp after 1 cycle -> rmask=1000, rd_v=0xFFFF_FF80. Repeat as LBU -> rd_v=0x0000_0080.
- SH at 0x102, rs2_v=0x0000_1234 -> dmem_addr=0x100, wmask=1100, wdata=0x1234_0000, mem_wb_reg.regf_we=0.
- ADDI (non-memory), rd_v=0x5 -> mem_wb_reg.commit=1 with rd_v=5 on the next edge; masks stay 0; mem_stall never asserts.
- Assert rst two cycles into WAIT, then fire dmem_resp after release -> state IDLE, mem_wb_reg.commit stays 0, no commit emitted.
- Two consecutive LWs with 1-cycle resp latency -> second rmask pulse the cycle after the first resp; orders N, N+1 each commit once, in order.
